// File: rtl/load_sequencer.sv
// load_sequencer: multicycle controller that walks a RISC-V load across the
// shared 32-bit datapath bus. Memory drives the bus first (the sign extender
// captures it), then the sign extender drives it while the register file
// captures. Every bus-driver enable decodes from a single registered state,
// so at most one driver is active in any cycle.
module load_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       ext_wr,
  output logic [2:0] ext_op,
  output logic       ext_rd,
  output logic       reg_wr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    EXT  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Final counter value allowed without mem_ready; only meaningful when enabled.
  localparam logic [CNT_W-1:0] CNT_LAST =
    TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       op, op_next;

  function automatic logic legal_funct3(input logic [2:0] f);
    case (f)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_funct3 = 1'b1;
      default:                                legal_funct3 = 1'b0;
    endcase
  endfunction

  // State, wait counter and latched operation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      op    <= op_next;
    end
  end

  // Next-state, counter and op-latch decisions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = op;
    case (state)
      IDLE: begin
        if (start) begin
          if (legal_funct3(funct3)) begin
            op_next    = funct3;
            state_next = MEM;
          end else begin
            state_next = ERR;
          end
        end
      end
      MEM: begin
        // mem_ready in the last permitted cycle takes priority over timeout.
        if (mem_ready) begin
          state_next = EXT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
          if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            state_next = ERR;
          end
        end
      end
      EXT: begin
        state_next = IDLE;
      end
      ERR: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode from registered state; ext_wr alone also looks at mem_ready.
  always_comb begin
    mem_rd = 1'b0;
    ext_wr = 1'b0;
    ext_rd = 1'b0;
    reg_wr = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (state)
      MEM: begin
        mem_rd = 1'b1;
        ext_wr = mem_ready;
        busy   = 1'b1;
      end
      EXT: begin
        ext_rd = 1'b1;
        reg_wr = 1'b1;
        done   = 1'b1;
        busy   = 1'b1;
      end
      ERR: begin
        err  = 1'b1;
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign ext_op = op;

endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
- Multicycle controller that sequences a RISC-V load through the shared 32-bit tri-state datapath bus.
- Drives the memory read-enable, then the sign extender write, operation select and read-enable, then the register-file write strobe.
- Guarantees that only one bus driver is active in any cycle.
- Sits between the core control FSM (start/done) and the memory, sign extender and register file.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_ready before aborting; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin a load; sampled only in IDLE.
- funct3  in  3  load funct3; sampled with start. Legal values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_ready  in  1  memory has valid read data on the bus this cycle.
- mem_rd  out  1  memory drives the bus.
- ext_wr  out  1  sign extender captures the bus.
- ext_op  out  3  sign extender operation; holds the latched funct3.
- ext_rd  out  1  sign extender drives the bus.
- reg_wr  out  1  register file captures the bus.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse: load completed.
- err  out  1  one-cycle pulse: illegal funct3 or timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, op register 000. Reset asserted mid-sequence aborts immediately; no done or err pulse follows.
- States: IDLE, MEM, EXT, ERR.
- IDLE, start=1, legal funct3: latch funct3 into the op register, go to MEM.
- IDLE, start=1, illegal funct3 (011, 110, 111): go to ERR; the op register is unchanged.
- IDLE, start=0: stay in IDLE.
- MEM: mem_rd=1, busy=1.
  - ext_wr = mem_rd & mem_ready, combinational, so the extender captures in the same cycle the memory drives the bus.
  - mem_ready=1: go to EXT and clear the counter.
  - mem_ready=0: increment the counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 in a mem_ready=0 cycle, go to ERR. That is, TIMEOUT_CYCLES cycles of mem_rd are allowed in total; ext_wr is never asserted.
  - mem_ready arriving in the final allowed cycle wins over the timeout.
- EXT: ext_rd=1, reg_wr=1, done=1, busy=1; next state IDLE.
- ERR: err=1, busy=1; next state IDLE; the counter is cleared.
- mem_rd, ext_rd, reg_wr, done, err and busy decode from the registered state. ext_op is the registered op value and is stable from MEM through EXT.
- Invariant: mem_rd & ext_rd never 1 in the same cycle.
- ext_wr is asserted only in MEM.
- start is ignored while busy=1; there is no queueing.
- Back-to-back loads: start may be asserted in the cycle after EXT (state IDLE).
- Latency with a zero-wait memory:
  - start sampled at edge 0.
  - MEM in cycle 1.
  - EXT/done in cycle 2.
  - IDLE in cycle 3.
- mem_ready outside MEM has no effect.

Test Plan:
- Reset, then start=1, funct3=000, mem_ready=1 in cycle 1:
  - cycle 1: mem_rd=1, ext_wr=1, ext_op=000.
  - cycle 2: ext_rd=1, reg_wr=1, done=1.
  - cycle 3: busy=0. With the bus carrying 0x00000080 and the real extender attached, the register file receives 0xFFFFFF80.
- funct3=101, mem_ready delayed 3 cycles:
  - mem_rd high for 4 cycles; ext_wr only in the 4th.
  - done exactly 1 cycle; with bus 0x1234F00D the register file receives 0x0000F00D.
- funct3=110: next cycle err=1, busy=1, no mem_rd/ext_rd/reg_wr; IDLE the following cycle.
- TIMEOUT_CYCLES=4, mem_ready held 0:
  - mem_rd high 4 cycles, then err=1 for 1 cycle; ext_wr and done never asserted.
  - Rerun with mem_ready=1 in the 4th cycle: done, no err.
- Assert rst in the EXT cycle: all outputs drop to 0 asynchronously; no done or err after release; the next start completes normally.
- Randomized 1000 loads with random funct3 and random mem_ready delays, start pulsed while busy:
  - checker asserts mem_rd&ext_rd==0 every cycle.
  - exactly one done or err per accepted start.
  - starts issued while busy are ignored.
